light_pwm_ctrl: RTL and testbench



---
 rtl/light_pwm_ctrl.sv | 136 +++++++++++++
 tb/tb_light_pwm_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/light_pwm_ctrl.sv
// light_pwm_ctrl: maps a 0-4 light level to a PWM duty, fades toward it, and
// swaps the active duty only at period boundaries. Fading needs LIGHT_PWM_FADE_EN.
`default_nettype none

module light_pwm_ctrl #(
  parameter int PWM_W    = 8,
  parameter int RAMP_DIV = 1000,
  parameter int STEP     = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_level,
  output logic             o_pwm,
  output logic [PWM_W-1:0] o_duty,
  output logic             o_busy
);

  localparam logic [PWM_W-1:0] MAX_C    = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] CNT_LAST = MAX_C - 1'b1;

  if (RAMP_DIV < 1 || STEP < 1) begin : g_param_check
    $error("light_pwm_ctrl: RAMP_DIV and STEP must both be >= 1");
  end

  logic [PWM_W-1:0] target_duty;
  logic [PWM_W-1:0] cur_duty_q, cur_duty_d;
  logic [PWM_W-1:0] act_duty_q;
  logic [PWM_W-1:0] cnt_q;
  logic             pwm_q;

  always_comb begin
    target_duty = '0;
    case (i_level)
      3'd1:    target_duty = MAX_C >> 2;
      3'd2:    target_duty = MAX_C >> 1;
      3'd3:    target_duty = MAX_C - (MAX_C >> 2);
      3'd4:    target_duty = MAX_C;
      default: target_duty = '0;
    endcase
  end

`ifdef LIGHT_PWM_FADE_EN
  localparam int               DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  // Steps wider than the duty range can never be taken in full.
  localparam logic [PWM_W-1:0] STEP_C   = (STEP > (2**PWM_W - 1)) ? MAX_C : PWM_W'(STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [PWM_W-1:0] diff, step_amt;
  logic [PWM_W:0]   up_sum;
  logic             step_edge;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    diff       = (target_duty > cur_duty_q) ? (target_duty - cur_duty_q)
                                            : (cur_duty_q - target_duty);
    step_amt   = (diff < STEP_C) ? diff : STEP_C;
    up_sum     = {1'b0, cur_duty_q} + {1'b0, step_amt};
    step_edge  = 1'b0;
    state_d    = state_q;
    div_cnt_d  = '0;
    cur_duty_d = cur_duty_q;
    case (state_q)
      IDLE: begin
        if (target_duty > cur_duty_q)      state_d = RAMP_UP;
        else if (target_duty < cur_duty_q) state_d = RAMP_DOWN;
      end
      RAMP_UP, RAMP_DOWN: begin
        if (target_duty == cur_duty_q) begin
          state_d = IDLE;
        end else begin
          step_edge = (div_cnt_q == DIV_LAST);
          div_cnt_d = step_edge ? '0 : div_cnt_q + 1'b1;
          // The step follows the current state; a reversal is seen next cycle.
          if (step_edge) begin
            if (state_q == RAMP_UP)
              cur_duty_d = up_sum[PWM_W] ? MAX_C : up_sum[PWM_W-1:0];
            else
              cur_duty_d = (step_amt > cur_duty_q) ? '0 : (cur_duty_q - step_amt);
          end
          state_d = (target_duty > cur_duty_q) ? RAMP_UP : RAMP_DOWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);
`else
  always_comb begin
    cur_duty_d = target_duty;
  end

  assign o_busy = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cur_duty_q <= '0;
      act_duty_q <= '0;
      cnt_q      <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cur_duty_q <= cur_duty_d;
      pwm_q      <= (cnt_q < act_duty_q);
      if (cnt_q == CNT_LAST) begin
        cnt_q      <= '0;
        act_duty_q <= cur_duty_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_pwm  = pwm_q;
  assign o_duty = cur_duty_q;

endmodule

`default_nettype wire

// File: tb/tb_light_pwm_ctrl.sv
// tb_light_pwm_ctrl: directed bench for light_pwm_ctrl at PWM_W=4, RAMP_DIV=2, STEP=1.
// Expectations cover both the faded and the non-faded build.
`default_nettype none

module tb_light_pwm_ctrl;
  localparam int PWM_W = 4;
`ifdef LIGHT_PWM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       level;
  logic             pwm;
  logic [PWM_W-1:0] duty;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  light_pwm_ctrl #(.PWM_W(PWM_W), .RAMP_DIV(2), .STEP(1)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_level (level),
    .o_pwm   (pwm),
    .o_duty  (duty),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_pwm"},  32'(pwm),  0);
    check_eq({tag, "_duty"}, 32'(duty), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_d;
    int exp_a;
    int busy_cnt;

    // Reset held with a non-zero level request.
    rst   = 1'b1;
    level = 3'd4;
    #1;
    check_zero("rst_t0");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_zero("rst_held");
    end
    rst = 1'b0;

    // Fade 0 -> 15 at level 4; pwm saturates after the boundary that latches 15.
    busy_cnt = 0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      exp_d = FADE ? (((k - 1) / 2 > 15) ? 15 : (k - 1) / 2) : 15;
      check_eq("s2_duty", 32'(duty), 32'(exp_d));
      if (busy) busy_cnt++;
      if (k >= 46) check_eq("s2_pwm_high", 32'(pwm), 1);
    end
    check_eq("s2_busy_cycles", 32'(busy_cnt), FADE ? 31 : 0);

    // Level 2: duty 7, pwm high for cnt 0..6 of each period.
    level = 3'd2;
    for (int k = 76; k <= 122; k++) begin
      tick();
      if (k == 105) begin
        check_eq("s3_duty", 32'(duty), 7);
        check_eq("s3_busy", 32'(busy), 0);
      end
      if (k >= 106 && k <= 120)
        check_eq("s3_pwm", 32'(pwm), 32'(((k - 1) % 15) < 7));
      if (k == 122) check_eq("s3_pwm_pre_rst", 32'(pwm), 1);
    end

    // Asynchronous reset between clock edges.
    #($urandom_range(7, 1));
    rst   = 1'b1;
    level = 3'd4;
    #1;
    check_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("rst_held2");
    end
    rst = 1'b0;

    // Reverse to level 0 once duty reaches 5.
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 11) begin
        check_eq("s4_duty_at_turn", 32'(duty), FADE ? 5 : 15);
        level = 3'd0;
      end
      if (k >= 12) begin
        exp_d = FADE ? ((5 - (k - 11) / 2 < 0) ? 0 : 5 - (k - 11) / 2) : 0;
        check_eq("s4_duty", 32'(duty), 32'(exp_d));
        check_eq("s4_busy", 32'(busy), 32'(FADE && (k <= 21)));
      end
      if (k >= 31) check_eq("s4_pwm_low", 32'(pwm), 0);
    end

    // Level 3 then invalid level 6, which targets 0.
    level = 3'd3;
    for (int k = 61; k <= 116; k++) begin
      tick();
      if (k == 90) begin
        check_eq("s5_duty_l3", 32'(duty), 12);
        check_eq("s5_busy_l3", 32'(busy), 0);
        level = 3'd6;
      end
      if (k == 91) begin
        check_eq("s5_duty_first", 32'(duty), FADE ? 12 : 0);
        check_eq("s5_busy_first", 32'(busy), FADE ? 1 : 0);
      end
      if (k == 103) check_eq("s5_duty_mid", 32'(duty), FADE ? 6 : 0);
      if (k == 115) begin
        check_eq("s5_duty_end", 32'(duty), 0);
        check_eq("s5_busy_end", 32'(busy), FADE ? 1 : 0);
      end
      if (k == 116) check_eq("s5_busy_done", 32'(busy), 0);
    end

    // Level 1 -> 3 at cnt 5: the running period keeps its 3-clock high time.
    level = 3'd1;
    for (int k = 117; k <= 180; k++) begin
      tick();
      if (k >= 136) begin
        exp_a = (k <= 150) ? 3 : (k <= 165) ? (FADE ? 7 : 12) : 12;
        check_eq("s6_pwm", 32'(pwm), 32'(((k - 1) % 15) < exp_a));
      end
      if (k == 140) level = 3'd3;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
